mem_access_arbiter: RTL and testbench
=====================================

# mem_access_arbiter

Shares the single external memory port between the I-cache refill engine and the D-cache MSHRs (CONF_DCACHE_MSHR_NUM entries). It performs round-robin arbitration over line-sized read and write requests and drives one registered memory request slot. It tracks outstanding reads per requester and routes tagged read responses back. It sits between the cache miss handlers and the memory interface.

## Interface
- REQ_NUM, 3: requesters; index 0 = I-cache, 1..REQ_NUM-1 = D-cache MSHR 0..REQ_NUM-2.
- ADDR_WIDTH, 32: physical address width.
- LINE_WIDTH, 64: line data width (8-byte line).
- MAX_OUTSTANDING, 2: maximum reads in flight at memory (1..REQ_NUM).
- TAG_WIDTH, $clog2(REQ_NUM): memory tag width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- reqValid  in  REQ_NUM  request pending, per requester.
- reqWrite  in  REQ_NUM  1 = write-back, 0 = line read.
- reqAddr  in  REQ_NUM×ADDR_WIDTH  line address.
- reqData  in  REQ_NUM×LINE_WIDTH  write data.
- reqGrant  out  REQ_NUM  one-hot pulse: request accepted this cycle.
- memReqValid  out  1  memory request slot valid.
- memReqReady  in  1  memory accepts the slot this cycle.
- memReqWrite  out  1  slot is a write.
- memReqAddr  out  ADDR_WIDTH  slot address.
- memReqData  out  LINE_WIDTH  slot write data.
- memReqTag  out  TAG_WIDTH  requester index of the slot.
- memRespValid  in  1  read response valid.
- memRespTag  in  TAG_WIDTH  response tag.
- memRespData  in  LINE_WIDTH  response line.
- respValid  out  REQ_NUM  one-hot, one-cycle response pulse.
- respData  out  LINE_WIDTH  response line, shared by all requesters.
- errorTag  out  1  sticky: response with invalid or unexpected tag.

## Operation
- Eligible(i) = reqValid[i] && !busy[i] && (reqWrite[i] || outCount < MAX_OUTSTANDING).
- Slot free = !memReqValid || memReqReady.
- Arbitration happens only when the slot is free. The winner is the first eligible index at or after rrPtr, modulo REQ_NUM. reqGrant[winner]=1 combinationally in that cycle. Grants are never issued while the slot is held.
- On a grant edge:
  - Slot loads addr, data, write, and tag = winner; memReqValid=1.
  - rrPtr = (winner+1) mod REQ_NUM.
  - For a read: busy[winner]=1 and outCount+1.
- A requester keeps its request stable until granted. It deasserts in the cycle after the grant. A write is complete at grant; no response follows.
- On a slot-accept edge with no new grant: memReqValid=0.
- Response edge (memRespValid, tag t):
  - If t<REQ_NUM and busy[t]: respValid[t]=1 and respData=memRespData on the next cycle, busy[t]=0, outCount-1.
  - Otherwise: errorTag=1 (sticky), and state is unchanged.
- A read grant and a response in the same cycle leave outCount unchanged. Each busy bit updates independently.
- A requester is masked while busy[i]=1. A response can therefore never coincide with a grant to the same index.
- rst in any cycle clears everything, including any pending slot and all in-flight bookkeeping. Responses arriving after reset are errors.

## Timing
- Reset values:
  - Outputs: reqGrant=0, memReqValid=0, memReqWrite=0, memReqAddr=0, memReqData=0, memReqTag=0, respValid=0, respData=0, errorTag=0.
  - Internal: rrPtr=0, busy=0, outCount=0.
- Grant latency is 0 cycles from an eligible request with a free slot. memReqValid is asserted on the next cycle.
- Back-to-back: if memReqReady=1 every cycle, one grant per cycle is sustained.
- Response-to-respValid latency is 1 cycle (registered). respValid is a single-cycle pulse with no backpressure.
- All outputs are registered except reqGrant.

## Test plan
- Single read, REQ 1 addr 0x100: grant at cycle 0, memReqValid with tag 1 at cycle 1, then ready. memRespValid with tag 1 and data 0xDEAD_BEEF_0123_4567 → respValid=3'b010 and that data 1 cycle later; busy cleared.
- All three request reads with ready=1: grants in order 0, 1 (outCount=2), then requester 2 is held until the first response. After the response, 2 is granted in the same cycle the count drops.
- Backpressure: ready=0 for 5 cycles → the slot holds addr, data and tag stable, with no grants. When ready=1, a grant to the next requester occurs in that same cycle.
- Write while outCount=MAX: requester 2 write to 0x200 is granted immediately, and outCount stays 2 with no respValid.
- Simultaneous read grant to 2 and response with tag 0: outCount is unchanged, busy goes from 3'b001 to 3'b100, and respValid=3'b001.
- Response with tag 3 or tag of a non-busy requester → errorTag=1 and stays set. A mid-flight rst clears busy and outCount, and a later response also sets errorTag.

Source files
------------

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: round-robin sharing of one registered memory request slot among I-cache and D-cache MSHRs
module mem_access_arbiter #(
    parameter int REQ_NUM         = 3,
    parameter int ADDR_WIDTH      = 32,
    parameter int LINE_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 2,
    parameter int TAG_WIDTH       = $clog2(REQ_NUM)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [REQ_NUM-1:0]                   reqValid,
    input  logic [REQ_NUM-1:0]                   reqWrite,
    input  logic [REQ_NUM-1:0][ADDR_WIDTH-1:0]   reqAddr,
    input  logic [REQ_NUM-1:0][LINE_WIDTH-1:0]   reqData,
    output logic [REQ_NUM-1:0]                   reqGrant,
    output logic                                 memReqValid,
    input  logic                                 memReqReady,
    output logic                                 memReqWrite,
    output logic [ADDR_WIDTH-1:0]                memReqAddr,
    output logic [LINE_WIDTH-1:0]                memReqData,
    output logic [TAG_WIDTH-1:0]                 memReqTag,
    input  logic                                 memRespValid,
    input  logic [TAG_WIDTH-1:0]                 memRespTag,
    input  logic [LINE_WIDTH-1:0]                memRespData,
    output logic [REQ_NUM-1:0]                   respValid,
    output logic [LINE_WIDTH-1:0]                respData,
    output logic                                 errorTag
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [TAG_WIDTH-1:0] LAST = TAG_WIDTH'(REQ_NUM - 1);

    logic [REQ_NUM-1:0]   busy;
    logic [REQ_NUM-1:0]   eligible;
    logic [REQ_NUM-1:0]   resp_vec;
    logic [CW-1:0]        out_count;
    logic [TAG_WIDTH-1:0] rr_ptr;
    logic [TAG_WIDTH-1:0] winner;
    logic [TAG_WIDTH-1:0] next_ptr;
    logic                 found;
    logic                 grant_any;
    logic                 grant_read;
    logic                 resp_hit;
    logic                 slot_free;

    // eligibility: busy requesters are masked, reads also need a free outstanding credit
    always_comb begin
        slot_free = !memReqValid || memReqReady;
        for (int i = 0; i < REQ_NUM; i++)
            eligible[i] = reqValid[i] && !busy[i] && (reqWrite[i] || out_count < MAX_CNT);
    end

    // round-robin pick: first eligible at or above rr_ptr, then wrap to the lowest below it
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < REQ_NUM; i++)
            if (!found && eligible[i] && TAG_WIDTH'(i) >= rr_ptr) begin
                found  = 1'b1;
                winner = TAG_WIDTH'(i);
            end
        for (int i = 0; i < REQ_NUM; i++)
            if (!found && eligible[i]) begin
                found  = 1'b1;
                winner = TAG_WIDTH'(i);
            end
        grant_any = found && slot_free;
        for (int i = 0; i < REQ_NUM; i++)
            reqGrant[i] = grant_any && winner == TAG_WIDTH'(i);
        grant_read = |(reqGrant & ~reqWrite);
        next_ptr   = (winner == LAST) ? '0 : winner + TAG_WIDTH'(1);
    end

    // response decode: only a tag naming a busy requester is a legal response
    always_comb begin
        for (int i = 0; i < REQ_NUM; i++)
            resp_vec[i] = memRespValid && memRespTag == TAG_WIDTH'(i) && busy[i];
        resp_hit = |resp_vec;
    end

    // request slot: load on grant, drop once memory accepts without a replacement
    always_ff @(posedge clk) begin
        if (rst) begin
            memReqValid <= 1'b0;
            memReqWrite <= 1'b0;
            memReqAddr  <= '0;
            memReqData  <= '0;
            memReqTag   <= '0;
            rr_ptr      <= '0;
        end else if (grant_any) begin
            memReqValid <= 1'b1;
            memReqWrite <= reqWrite[winner];
            memReqAddr  <= reqAddr[winner];
            memReqData  <= reqData[winner];
            memReqTag   <= winner;
            rr_ptr      <= next_ptr;
        end else if (memReqReady) begin
            memReqValid <= 1'b0;
        end
    end

    // in-flight read bookkeeping: set on read grant, clear on matching response
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= '0;
            out_count <= '0;
        end else begin
            busy      <= (busy & ~resp_vec) | (reqGrant & ~reqWrite);
            out_count <= out_count + CW'(grant_read) - CW'(resp_hit);
        end
    end

    // response return path and sticky error on bad or unexpected tags
    always_ff @(posedge clk) begin
        if (rst) begin
            respValid <= '0;
            respData  <= '0;
            errorTag  <= 1'b0;
        end else begin
            respValid <= resp_vec;
            respData  <= resp_hit ? memRespData : respData;
            errorTag  <= errorTag || (memRespValid && !resp_hit);
        end
    end
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: directed self-checking bench for mem_access_arbiter
module tb_mem_access_arbiter;
    logic            clk;
    logic            rst;
    logic [2:0]      req_valid;
    logic [2:0]      req_write;
    logic [2:0][31:0] req_addr;
    logic [2:0][63:0] req_data;
    logic [2:0]      req_grant;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_req_write;
    logic [31:0]     mem_req_addr;
    logic [63:0]     mem_req_data;
    logic [1:0]      mem_req_tag;
    logic            mem_resp_valid;
    logic [1:0]      mem_resp_tag;
    logic [63:0]     mem_resp_data;
    logic [2:0]      resp_valid;
    logic [63:0]     resp_data;
    logic            error_tag;
    int              n_chk;
    int              n_fail;

    mem_access_arbiter dut (
        .clk(clk), .rst(rst),
        .reqValid(req_valid), .reqWrite(req_write), .reqAddr(req_addr), .reqData(req_data),
        .reqGrant(req_grant),
        .memReqValid(mem_req_valid), .memReqReady(mem_req_ready), .memReqWrite(mem_req_write),
        .memReqAddr(mem_req_addr), .memReqData(mem_req_data), .memReqTag(mem_req_tag),
        .memRespValid(mem_resp_valid), .memRespTag(mem_resp_tag), .memRespData(mem_resp_data),
        .respValid(resp_valid), .respData(resp_data), .errorTag(error_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr = '0;
        req_data = '0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_tag = '0;
        mem_resp_data = '0;
        tick;
        tick;
        rst = 1'b0;
        chk("rst_grant", req_grant, 3'b000);
        chk("rst_mvalid", mem_req_valid, 1'b0);
        chk("rst_maddr", mem_req_addr, 32'h0);
        chk("rst_mtag", mem_req_tag, 2'd0);
        chk("rst_resp", resp_valid, 3'b000);
        chk("rst_rdata", resp_data, 64'h0);
        chk("rst_err", error_tag, 1'b0);
        chk("rst_busy", dut.busy, 3'b000);
        chk("rst_cnt", dut.out_count, 2'd0);

        // single read from requester 1
        req_valid = 3'b010;
        req_addr[1] = 32'h100;
        #2 chk("t1_grant", req_grant, 3'b010);
        tick;
        req_valid = 3'b000;
        chk("t1_mvalid", mem_req_valid, 1'b1);
        chk("t1_mtag", mem_req_tag, 2'd1);
        chk("t1_maddr", mem_req_addr, 32'h100);
        chk("t1_mwrite", mem_req_write, 1'b0);
        chk("t1_busy", dut.busy, 3'b010);
        chk("t1_cnt", dut.out_count, 2'd1);
        mem_req_ready = 1'b1;
        #2 chk("t1_nogrant", req_grant, 3'b000);
        tick;
        chk("t1_accepted", mem_req_valid, 1'b0);
        mem_resp_valid = 1'b1;
        mem_resp_tag = 2'd1;
        mem_resp_data = 64'hDEAD_BEEF_0123_4567;
        tick;
        mem_resp_valid = 1'b0;
        chk("t1_resp", resp_valid, 3'b010);
        chk("t1_rdata", resp_data, 64'hDEAD_BEEF_0123_4567);
        chk("t1_busy_clr", dut.busy, 3'b000);
        chk("t1_cnt_clr", dut.out_count, 2'd0);
        chk("t1_err", error_tag, 1'b0);
        tick;
        chk("t1_pulse", resp_valid, 3'b000);

        // reset to bring the round-robin pointer back to 0
        rst = 1'b1;
        tick;
        rst = 1'b0;

        // three reads competing with ready held high
        req_valid = 3'b111;
        req_addr[0] = 32'h1000;
        req_addr[1] = 32'h2000;
        req_addr[2] = 32'h3000;
        #2 chk("t2_g0", req_grant, 3'b001);
        tick;
        chk("t2_tag0", mem_req_tag, 2'd0);
        chk("t2_addr0", mem_req_addr, 32'h1000);
        chk("t2_cnt1", dut.out_count, 2'd1);
        req_valid = 3'b110;
        #2 chk("t2_g1", req_grant, 3'b010);
        tick;
        chk("t2_tag1", mem_req_tag, 2'd1);
        chk("t2_cnt2", dut.out_count, 2'd2);
        chk("t2_busy", dut.busy, 3'b011);
        req_valid = 3'b100;
        #2 chk("t2_hold2", req_grant, 3'b000);
        tick;
        chk("t2_idle", mem_req_valid, 1'b0);
        mem_resp_valid = 1'b1;
        mem_resp_tag = 2'd0;
        mem_resp_data = 64'hAAAA_0000_BBBB_1111;
        #2 chk("t2_hold2b", req_grant, 3'b000);
        tick;
        mem_resp_valid = 1'b0;
        chk("t2_resp0", resp_valid, 3'b001);
        chk("t2_rdata0", resp_data, 64'hAAAA_0000_BBBB_1111);
        chk("t2_cnt_drop", dut.out_count, 2'd1);
        chk("t2_busy_drop", dut.busy, 3'b010);
        #2 chk("t2_g2", req_grant, 3'b100);
        tick;
        req_valid = 3'b000;
        chk("t2_tag2", mem_req_tag, 2'd2);
        chk("t2_addr2", mem_req_addr, 32'h3000);
        chk("t2_cnt_back", dut.out_count, 2'd2);
        chk("t2_busy2", dut.busy, 3'b110);
        mem_resp_valid = 1'b1;
        mem_resp_tag = 2'd1;
        tick;
        chk("t2_resp1", resp_valid, 3'b010);
        mem_resp_tag = 2'd2;
        tick;
        mem_resp_valid = 1'b0;
        chk("t2_resp2", resp_valid, 3'b100);
        chk("t2_cnt0", dut.out_count, 2'd0);
        chk("t2_busy0", dut.busy, 3'b000);

        // read grant to 2 coinciding with response to 0
        req_valid = 3'b001;
        req_addr[0] = 32'h1100;
        #2 chk("t3_g0", req_grant, 3'b001);
        tick;
        chk("t3_busy_pre", dut.busy, 3'b001);
        chk("t3_cnt_pre", dut.out_count, 2'd1);
        req_valid = 3'b100;
        req_addr[2] = 32'h3100;
        mem_resp_valid = 1'b1;
        mem_resp_tag = 2'd0;
        mem_resp_data = 64'h1234_5678_9ABC_DEF0;
        #2 chk("t3_g2", req_grant, 3'b100);
        tick;
        req_valid = 3'b000;
        chk("t3_cnt_same", dut.out_count, 2'd1);
        chk("t3_busy_swap", dut.busy, 3'b100);
        chk("t3_resp0", resp_valid, 3'b001);
        chk("t3_rdata", resp_data, 64'h1234_5678_9ABC_DEF0);
        chk("t3_mtag", mem_req_tag, 2'd2);
        mem_resp_tag = 2'd2;
        tick;
        mem_resp_valid = 1'b0;
        chk("t3_busy0", dut.busy, 3'b000);
        chk("t3_cnt0", dut.out_count, 2'd0);

        // write admitted while reads are at the limit
        req_valid = 3'b011;
        #2 chk("t4_g0", req_grant, 3'b001);
        tick;
        req_valid = 3'b010;
        #2 chk("t4_g1", req_grant, 3'b010);
        tick;
        chk("t4_cnt_max", dut.out_count, 2'd2);
        req_valid = 3'b100;
        req_write = 3'b100;
        req_addr[2] = 32'h200;
        req_data[2] = 64'h55AA;
        #2 chk("t4_gw", req_grant, 3'b100);
        tick;
        chk("t4_mwrite", mem_req_write, 1'b1);
        chk("t4_maddr", mem_req_addr, 32'h200);
        chk("t4_mdata", mem_req_data, 64'h55AA);
        chk("t4_mtag", mem_req_tag, 2'd2);
        chk("t4_cnt", dut.out_count, 2'd2);
        chk("t4_busy", dut.busy, 3'b011);
        chk("t4_noresp", resp_valid, 3'b000);

        // backpressure: slot held stable, grant released in the cycle ready returns
        mem_req_ready = 1'b0;
        req_addr[2] = 32'h240;
        req_data[2] = 64'h6677;
        for (int c = 0; c < 5; c++) begin
            #2 chk("t5_nogrant", req_grant, 3'b000);
            tick;
            chk("t5_hold_v", mem_req_valid, 1'b1);
            chk("t5_hold_a", mem_req_addr, 32'h200);
            chk("t5_hold_d", mem_req_data, 64'h55AA);
            chk("t5_hold_t", mem_req_tag, 2'd2);
        end
        mem_req_ready = 1'b1;
        #2 chk("t5_grant", req_grant, 3'b100);
        tick;
        req_valid = 3'b000;
        req_write = 3'b000;
        chk("t5_new_a", mem_req_addr, 32'h240);
        chk("t5_new_d", mem_req_data, 64'h6677);
        tick;
        chk("t5_drain", mem_req_valid, 1'b0);

        // tag errors, then reset while reads are in flight
        mem_resp_valid = 1'b1;
        mem_resp_tag = 2'd2;
        tick;
        chk("t6_err_nb", error_tag, 1'b1);
        chk("t6_noresp", resp_valid, 3'b000);
        chk("t6_cnt", dut.out_count, 2'd2);
        chk("t6_busy", dut.busy, 3'b011);
        mem_resp_tag = 2'd3;
        tick;
        mem_resp_valid = 1'b0;
        chk("t6_err_t3", error_tag, 1'b1);
        chk("t6_busy_t3", dut.busy, 3'b011);
        tick;
        chk("t6_sticky", error_tag, 1'b1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("t6_rst_busy", dut.busy, 3'b000);
        chk("t6_rst_cnt", dut.out_count, 2'd0);
        chk("t6_rst_err", error_tag, 1'b0);
        mem_resp_valid = 1'b1;
        mem_resp_tag = 2'd0;
        tick;
        mem_resp_valid = 1'b0;
        chk("t6_late_err", error_tag, 1'b1);
        chk("t6_late_resp", resp_valid, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
